ieee754_div: RTL and testbench
==============================

IEEE754_DIV -- requirements
Module: ieee754_div

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request to divide; sampled only in IDLE.
REQ-004 SHALL have port a, input, 32 bits: IEEE-754 single-precision dividend.
REQ-005 SHALL have port b, input, 32 bits: IEEE-754 single-precision divisor.
REQ-006 SHALL have port result, output, 32 bits: IEEE-754 quotient a/b; held until the next completion.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when result is updated.
REQ-009 SHALL have port div_zero, output, 1 bit: set with done when b is zero and a is finite and nonzero; held until the next completion.

Function
REQ-010 SHALL implement states IDLE, CALC, NORM and DONE.
- IDLE->CALC on start=1.
- CALC->NORM after 26 iterations.
- NORM->DONE.
- DONE->IDLE unconditionally.
REQ-011 SHALL register a and b on the edge where start is sampled in IDLE; later changes to a and b SHALL NOT affect the operation.
REQ-012 SHALL ignore start whenever the state is not IDLE; it is neither queued nor able to restart the operation.
REQ-013 SHALL hold busy=1 in CALC, NORM and DONE, and busy=0 in IDLE.
REQ-014 SHALL assert done and update result and div_zero in the cycle after the edge that enters DONE.
- done falls one cycle later.
- Fixed latency: done is high exactly 28 cycles after the start-sampling edge, special cases included.
REQ-015 SHALL compute sign as a[31] XOR b[31] for every non-NaN result.
REQ-016 SHALL divide mantissas by restoring division on 24-bit significands with the implicit 1 restored: one quotient bit per CALC cycle, 26 bits total; sticky = OR of the final remainder.
REQ-017 SHALL form the exponent as ea - eb + 127 in at least 10-bit signed arithmetic.
- In NORM: if the quotient MSB is 0, shift left by one and decrement the exponent.
REQ-018 SHALL saturate overflow: biased exponent >= 255 after normalisation and rounding gives signed infinity.
REQ-019 SHALL flush underflow to signed zero: biased exponent <= 0 gives signed zero, with no denormal output.
REQ-020 SHALL treat denormal inputs (exponent 0, fraction nonzero) as signed zero.
REQ-021 SHALL apply special cases, highest priority first:
- Either operand NaN, 0/0, or inf/inf: result 32'h7FC00000.
- a infinite: signed infinity.
- b infinite: signed zero.
- b zero: signed infinity with div_zero=1.
- a zero: signed zero.

Reset
REQ-022 SHALL, while rst=1, immediately force state=IDLE, result=0, busy=0, done=0, div_zero=0 and all internal registers to 0.
REQ-023 SHALL, if rst asserts mid-operation, discard that operation with no done pulse; the next start after rst deasserts proceeds normally.

Configuration
REQ-024 SHALL, with macro IEEE754_DIV_ROUND_EN defined, round to nearest-even using guard bit and sticky.
- A mantissa carry-out increments the exponent and may produce overflow per REQ-018.
REQ-025 SHALL, without IEEE754_DIV_ROUND_EN, truncate the quotient toward zero.
- Latency and all other behaviour are identical.

Verification
REQ-026 Bench SHALL cover a=32'h41180000 (9.5), b=32'h40000000 (2.0) -> result=32'h40980000 (4.75), div_zero=0, done exactly 28 cycles after start.
REQ-027 Bench SHALL cover a=32'h40F00000 (7.5), b=32'hC0200000 (-2.5) -> result=32'hC0400000 (-3.0).
REQ-028 Bench SHALL cover a=32'h3F800000 (1.0), b=32'h40400000 (3.0) -> 32'h3EAAAAAB with IEEE754_DIV_ROUND_EN, 32'h3EAAAAAA without.
REQ-029 Bench SHALL cover a=32'h40980000, b=0 -> 32'h7F800000 with div_zero=1; then a=0, b=0 -> 32'h7FC00000 with div_zero=0.
REQ-030 Bench SHALL cover start pulses, and a/b changes, during busy -> ignored, first result unchanged, only one done pulse.
REQ-031 Bench SHALL cover rst asserted 10 cycles into an operation -> busy=0, done=0, result=0 immediately; a new start completes in 28 cycles.

Source files
------------

// File: rtl/ieee754_div.sv
// Multi-cycle IEEE-754 single-precision divider (restoring division, fixed 28-cycle latency).
// Define IEEE754_DIV_ROUND_EN for round-to-nearest-even; otherwise the quotient is truncated.
module ieee754_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);
    typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [24:0] rem_q, rem_d;
    logic [25:0] quo_q, quo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [9:0]  exp_q, exp_d;
    logic [31:0] result_q, result_d;
    logic        busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d;

    logic        sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [25:0] diff;
    logic        ge, round_inc;
    logic [23:0] mant_r;
    logic [9:0]  exp_r;

    // Denormal operands carry a zero exponent and are deliberately treated as zero.
    always_comb begin
        sign   = a_q[31] ^ b_q[31];
        a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
        b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
        a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
        a_zero = (a_q[30:23] == 8'h00);
        b_zero = (b_q[30:23] == 8'h00);
        diff   = {1'b0, rem_q} - {2'b00, 1'b1, b_q[22:0]};
        ge     = ~diff[25];
    end

    always_comb begin
`ifdef IEEE754_DIV_ROUND_EN
        logic guard, sticky;
        guard     = quo_q[1];
        sticky    = quo_q[0] | (|rem_q);
        round_inc = guard & (sticky | quo_q[2]);
`else
        round_inc = 1'b0;
`endif
        // A carry into bit 23 means the significand rounded up to 2.0.
        mant_r = {1'b0, quo_q[24:2]} + {23'd0, round_inc};
        exp_r  = mant_r[23] ? exp_q + 10'd1 : exp_q;
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        exp_d      = exp_q;
        result_d   = result_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    rem_d   = {2'b01, a[22:0]};
                    quo_d   = 26'd0;
                    cnt_d   = 5'd0;
                    exp_d   = {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'd127;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                quo_d = {quo_q[24:0], ge};
                rem_d = ge ? {diff[23:0], 1'b0} : {rem_q[23:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd25) state_d = NORM;
            end
            NORM: begin
                if (!quo_q[25]) begin
                    quo_d = {quo_q[24:0], 1'b0};
                    exp_d = exp_q - 10'd1;
                end
                state_d = DONE;
            end
            DONE: begin
                div_zero_d = 1'b0;
                if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
                    result_d = 32'h7FC00000;
                else if (a_inf)
                    result_d = {sign, 8'hFF, 23'd0};
                else if (b_inf)
                    result_d = {sign, 31'd0};
                else if (b_zero) begin
                    result_d   = {sign, 8'hFF, 23'd0};
                    div_zero_d = 1'b1;
                end else if (a_zero)
                    result_d = {sign, 31'd0};
                else if ($signed(exp_r) >= 10'sd255)
                    result_d = {sign, 8'hFF, 23'd0};
                else if ($signed(exp_r) <= 10'sd0)
                    result_d = {sign, 31'd0};
                else
                    result_d = {sign, exp_r[7:0], mant_r[22:0]};
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            rem_q      <= 25'd0;
            quo_q      <= 26'd0;
            cnt_q      <= 5'd0;
            exp_q      <= 10'd0;
            result_q   <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            exp_q      <= exp_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign result   = result_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
endmodule

// File: tb/tb_ieee754_div.sv
// Directed self-checking bench for ieee754_div; expected quotients are hand-computed.
module tb_ieee754_div;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] result;
    logic        busy, done, div_zero;

    int checks = 0;
    int errors = 0;

    ieee754_div dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .result(result), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic issue_start(input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 32'hDEADBEEF;
        b = 32'h12345678;
    endtask

    // Latency counts edges after the start-sampling edge; 0 means the wait timed out.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                          output logic [31:0] res, output logic dz, output int lat);
        issue_start(av, bv);
        wait_done(lat);
        res = result;
        dz  = div_zero;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (result !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: result=%h busy=%b done=%b dz=%b, want 0/0/0/0",
                     result, busy, done, div_zero);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [31:0] res;
        logic        dz;
        int          lat;
        logic [31:0] third;
`ifdef IEEE754_DIV_ROUND_EN
        third = 32'h3EAAAAAB;
`else
        third = 32'h3EAAAAAA;
`endif
        run_op(32'h41180000, 32'h40000000, res, dz, lat);
        checks++;
        if (res !== 32'h40980000 || dz !== 1'b0) begin
            errors++;
            $display("[TB] FAIL div_9p5_by_2: got %h dz=%b, want 40980000 dz=0", res, dz);
        end
        checks++;
        if (lat != 28) begin
            errors++;
            $display("[TB] FAIL latency: got %0d cycles, want 28", lat);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 32'h40980000) begin
            errors++;
            $display("[TB] FAIL done_pulse: done=%b busy=%b result=%h, want 0 0 40980000",
                     done, busy, result);
        end
        run_op(32'h40F00000, 32'hC0200000, res, dz, lat);
        checks++;
        if (res !== 32'hC0400000) begin
            errors++;
            $display("[TB] FAIL div_7p5_by_m2p5: got %h, want c0400000", res);
        end
        run_op(32'h3F800000, 32'h40400000, res, dz, lat);
        checks++;
        if (res !== third) begin
            errors++;
            $display("[TB] FAIL div_1_by_3: got %h, want %h", res, third);
        end
    endtask

    typedef struct {
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] want;
        logic        want_dz;
    } vec_t;

    task automatic test_specials;
        vec_t        tbl[12];
        logic [31:0] res;
        logic        dz;
        int          lat;
        tbl[0]  = '{32'h40980000, 32'h00000000, 32'h7F800000, 1'b1};
        tbl[1]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0};
        tbl[2]  = '{32'h7FC00001, 32'h40000000, 32'h7FC00000, 1'b0};
        tbl[3]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0};
        tbl[4]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0};
        tbl[5]  = '{32'h40000000, 32'hFF800000, 32'h80000000, 1'b0};
        tbl[6]  = '{32'hC0000000, 32'h80000000, 32'h7F800000, 1'b1};
        tbl[7]  = '{32'h80000000, 32'h40000000, 32'h80000000, 1'b0};
        tbl[8]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0};
        tbl[9]  = '{32'h80800000, 32'h40000000, 32'h80000000, 1'b0};
        tbl[10] = '{32'h00000001, 32'h3F800000, 32'h00000000, 1'b0};
        tbl[11] = '{32'h3F800000, 32'h00000001, 32'h7F800000, 1'b1};
        foreach (tbl[i]) begin
            run_op(tbl[i].av, tbl[i].bv, res, dz, lat);
            checks++;
            if (res !== tbl[i].want || dz !== tbl[i].want_dz || lat != 28) begin
                errors++;
                $display("[TB] FAIL special_%0d: %h/%h got %h dz=%b lat=%0d, want %h dz=%b lat=28",
                         i, tbl[i].av, tbl[i].bv, res, dz, lat, tbl[i].want, tbl[i].want_dz);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int pulses = 0;
        int first  = 0;
        issue_start(32'h41180000, 32'h40000000);
        for (int k = 1; k <= 45; k++) begin
            if (k == 5 || k == 12 || k == 27) begin
                @(negedge clk);
                start = 1'b1;
                a = 32'h3F800000;
                b = 32'h40400000;
                @(posedge clk);
                #1;
                start = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
            if (k == 20) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL busy_mid_op: busy=%b, want 1", busy);
                end
            end
            if (done) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        checks++;
        if (pulses != 1 || first != 28 || result !== 32'h40980000) begin
            errors++;
            $display("[TB] FAIL busy_ignore: pulses=%0d first=%0d result=%h, want 1 28 40980000",
                     pulses, first, result);
        end
    endtask

    task automatic test_mid_reset;
        logic [31:0] res;
        logic        dz;
        int          lat;
        int          pulses = 0;
        issue_start(32'h40F00000, 32'hC0200000);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || div_zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset: busy=%b done=%b result=%h dz=%b, want 0 0 0 0",
                     busy, done, result, div_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        checks++;
        if (pulses != 0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL no_done_after_reset: pulses=%0d busy=%b, want 0 0", pulses, busy);
        end
        run_op(32'h41180000, 32'h40000000, res, dz, lat);
        checks++;
        if (res !== 32'h40980000 || lat != 28) begin
            errors++;
            $display("[TB] FAIL restart_after_reset: got %h lat=%0d, want 40980000 lat=28", res, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_specials();
        test_busy_ignore();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
